rle_encoder: RTL

Run-length encoder that consumes one block of eight signed 12-bit integer DCT coefficients from the full DCT transform stage. It emits (zero-run, value) pairs on a valid/ready stream toward the packer. Each block is latched, then scanned one coefficient per cycle. Every nonzero coefficient produces one pair, and any trailing zeros collapse into a single end-of-block pair.

---
 rtl/rle_encoder_pkg.sv | 14 +
 rtl/rle_encoder_if.sv | 26 ++
 rtl/rle_coef_buffer.sv | 27 ++
 rtl/rle_encoder.sv | 113 +++++++++++
 4 files changed

// File: rtl/rle_encoder_pkg.sv
// Shared constants and state type for the run-length encoder.
package rle_encoder_pkg;
  localparam int unsigned N_COEF     = 8;
  localparam int unsigned DEF_COEF_W = 12;
  localparam int unsigned DEF_RUN_W  = 4;
  localparam int unsigned IDX_W      = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COEF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;
endpackage

// File: rtl/rle_encoder_if.sv
// Block input stream and (run, value) pair output stream of the encoder.
interface rle_encoder_if
  import rle_encoder_pkg::*;
#(
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned RUN_W  = DEF_RUN_W
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic signed [COEF_W-1:0] coef_z [N_COEF];
  logic                     out_valid;
  logic                     out_ready;
  logic [RUN_W-1:0]         out_run;
  logic signed [COEF_W-1:0] out_value;
  logic                     out_last;

  modport slave (
    input  in_valid, coef_z, out_ready,
    output in_ready, out_valid, out_run, out_value, out_last
  );

  modport master (
    output in_valid, coef_z, out_ready,
    input  in_ready, out_valid, out_run, out_value, out_last
  );
endinterface

// File: rtl/rle_coef_buffer.sv
// Eight-entry coefficient latch with an index-selected read port and zero flag.
module rle_coef_buffer
  import rle_encoder_pkg::*;
#(
  parameter int unsigned COEF_W = DEF_COEF_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic signed [COEF_W-1:0] i_coef [N_COEF],
  input  logic [IDX_W-1:0]         i_idx,
  output logic signed [COEF_W-1:0] o_coef,
  output logic                     o_zero
);
  logic signed [COEF_W-1:0] r_buf [N_COEF];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '{default: '0};
    end else if (i_load) begin
      r_buf <= i_coef;
    end
  end

  assign o_coef = r_buf[i_idx];
  assign o_zero = (o_coef == '0);
endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder: scans a latched 8-coefficient block and emits
// (zero-run, value) pairs, collapsing trailing zeros into one EOB pair.
module rle_encoder
  import rle_encoder_pkg::*;
#(
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned RUN_W  = DEF_RUN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  rle_encoder_if.slave  bus,
  output logic          busy
);
  state_t                   r_state, w_state;
  logic [IDX_W-1:0]         r_idx, w_idx;
  logic [RUN_W-1:0]         r_run, w_run;
  logic                     r_out_valid, w_out_valid;
  logic [RUN_W-1:0]         r_out_run, w_out_run;
  logic signed [COEF_W-1:0] r_out_value, w_out_value;
  logic                     r_out_last, w_out_last;
  logic                     w_load;
  logic signed [COEF_W-1:0] w_coef;
  logic                     w_zero;

  assign w_load = en && (r_state == IDLE) && bus.in_valid;

  rle_coef_buffer #(.COEF_W(COEF_W)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_coef (bus.coef_z),
    .i_idx  (r_idx),
    .o_coef (w_coef),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_run       <= '0;
      r_out_valid <= 1'b0;
      r_out_run   <= '0;
      r_out_value <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_run       <= w_run;
      r_out_valid <= w_out_valid;
      r_out_run   <= w_out_run;
      r_out_value <= w_out_value;
      r_out_last  <= w_out_last;
    end
  end

  // With en low every next value equals its register, freezing the block.
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_run       = r_run;
    w_out_valid = r_out_valid;
    w_out_run   = r_out_run;
    w_out_value = r_out_value;
    w_out_last  = r_out_last;
    if (en) begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            w_state = SCAN;
            w_idx   = '0;
            w_run   = '0;
          end
        end
        SCAN: begin
          if (w_zero && (r_idx != IDX_LAST)) begin
            w_run = r_run + 1'b1;
            w_idx = r_idx + 1'b1;
          end else begin
            // A zero at the final slot becomes the EOB pair, counting itself.
            w_state     = EMIT;
            w_out_valid = 1'b1;
            w_out_run   = w_zero ? r_run + 1'b1 : r_run;
            w_out_value = w_coef;
            w_out_last  = w_zero || (r_idx == IDX_LAST);
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            w_out_valid = 1'b0;
            w_run       = '0;
            if (r_out_last) begin
              w_state = IDLE;
              w_idx   = '0;
            end else begin
              w_state = SCAN;
              w_idx   = r_idx + 1'b1;
            end
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  assign bus.in_ready  = en && (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_run   = r_out_run;
  assign bus.out_value = r_out_value;
  assign bus.out_last  = r_out_last;
  assign busy          = (r_state != IDLE);
endmodule
